// File: rtl/code_capture_pkg.sv
// Shared types and widths for the product-code capture front end.
package code_capture_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      CAPTURE,
      WAIT_REL,
      REL_DB
   } state_t;

   localparam int CODE_W = 8;
   localparam int CNT_W  = 4;

endpackage

// File: rtl/code_capture_sync.sv
// Multi-flop synchronizer for asynchronous inputs, with a configurable reset
// value so active-low inputs can come out of reset in their idle level.
module sync_chain #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
      end else begin
         stages[0] <= d;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/code_capture.sv
// Synchronizes and debounces the capture key, latching the switch code on each
// clean press. Define CODE_CAPTURE_STABLE_EN to abort captures whose switches move.
module code_capture
   import code_capture_pkg::*;
#(
   parameter int WIDTH           = CODE_W,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             key_raw_n,
   output logic [WIDTH-1:0] code,
   output logic             code_valid,
   output logic             code_loaded,
   output logic [CNT_W-1:0] capture_cnt,
   output logic             err
);

   localparam int            DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_SAT  = DB_W'(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] sw_s;
   logic [1:0]       key_pair;
   logic             key_s;
   logic             flushed;

   state_t           state;
   state_t           state_next;
   logic [DB_W-1:0]  db_cnt;
   logic             armed;
   logic             sw_changed;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             capture;

   sync_chain #(
      .WIDTH     (WIDTH),
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL ('0)
   ) u_sw_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw_raw),
      .q     (sw_s)
   );

   // A constant 1 travels beside the key so we can tell real released samples
   // from the reset value still draining out of the synchronizer.
   sync_chain #(
      .WIDTH     (2),
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL (2'b10)
   ) u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({key_raw_n, 1'b1}),
      .q     (key_pair)
   );

   assign key_s   = key_pair[1];
   assign flushed = key_pair[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:     if (!key_s && armed) state_next = PRESS_DB;
         PRESS_DB: begin
            if (key_s)                  state_next = IDLE;
            else if (sw_changed)        state_next = WAIT_REL;
            else if (db_cnt == DB_LAST) state_next = CAPTURE;
         end
         CAPTURE:  state_next = WAIT_REL;
         WAIT_REL: if (key_s) state_next = REL_DB;
         REL_DB: begin
            if (!key_s)                 state_next = WAIT_REL;
            else if (db_cnt == DB_LAST) state_next = IDLE;
         end
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      capture = 1'b0;
      if ((state == IDLE && state_next == PRESS_DB) ||
          (state == WAIT_REL && state_next == REL_DB)) cnt_clr = 1'b1;
      if ((state == PRESS_DB && !key_s) || (state == REL_DB && key_s)) cnt_inc = 1'b1;
      if (state == CAPTURE) capture = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              db_cnt <= '0;
      else if (cnt_clr)                        db_cnt <= '0;
      else if (cnt_inc && db_cnt != DB_SAT)    db_cnt <= db_cnt + 1'b1;
   end

   // A key held through reset must be seen genuinely released before it can count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   armed <= 1'b0;
      else if (state == IDLE && key_s && flushed)   armed <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code        <= '0;
         code_valid  <= 1'b0;
         code_loaded <= 1'b0;
         capture_cnt <= '0;
      end else begin
         code_valid <= capture;
         if (capture) begin
            code        <= sw_s;
            code_loaded <= 1'b1;
            capture_cnt <= capture_cnt + 1'b1;
         end
      end
   end

`ifdef CODE_CAPTURE_STABLE_EN
   logic [WIDTH-1:0] snap;
   logic             abort;

   assign sw_changed = (sw_s != snap);
   assign abort      = (state == PRESS_DB) && !key_s && sw_changed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap <= '0;
         err  <= 1'b0;
      end else begin
         err <= abort;
         if (state == IDLE && state_next == PRESS_DB) snap <= sw_s;
      end
   end
`else
   assign sw_changed = 1'b0;
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_code_capture.sv
// Scoreboard bench for code_capture with short debounce; expectations follow
// CODE_CAPTURE_STABLE_EN when it is defined.
module tb_code_capture;

   typedef struct packed {
      logic [7:0] code;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] sw_raw = 8'h00;
   logic       key_raw_n = 1'b1;
   logic [7:0] code;
   logic       code_valid;
   logic       code_loaded;
   logic [3:0] capture_cnt;
   logic       err;

   int   tests_run   = 0;
   int   fails       = 0;
   int   valid_count = 0;
   int   err_count   = 0;
   exp_t exp_q[$];
   exp_t exp_e;

   always #5 clk = ~clk;

   code_capture #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_raw      (sw_raw),
      .key_raw_n   (key_raw_n),
      .code        (code),
      .code_valid  (code_valid),
      .code_loaded (code_loaded),
      .capture_cnt (capture_cnt),
      .err         (err)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] sw, input logic key, input int cycles);
      sw_raw    = sw;
      key_raw_n = key;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pressRelease(input logic [7:0] sw, input logic [3:0] exp_cnt);
      exp_q.push_back('{code: sw, cnt: exp_cnt});
      applyStimulus(sw, 1'b1, 4);
      applyStimulus(sw, 1'b0, 12);
      applyStimulus(sw, 1'b1, 10);
   endtask

   // Monitor: every code_valid pulse must match the oldest outstanding capture.
   always @(negedge clk) begin
      if (err) err_count++;
      if (code_valid) begin
         valid_count++;
         if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("[TB] FAIL unexpected_valid: got code %0h, expected no capture", code);
         end else begin
            exp_e = exp_q.pop_front();
            checkOutput("sb_code", code, exp_e.code);
            checkOutput("sb_cnt", capture_cnt, exp_e.cnt);
            checkOutput("sb_loaded", code_loaded, 1);
         end
      end
   end

   initial begin
      int first_edge;
      int v0;
      int e0;

      #1 rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rst_code", code, 0);
      checkOutput("rst_valid", code_valid, 0);
      checkOutput("rst_loaded", code_loaded, 0);
      checkOutput("rst_cnt", capture_cnt, 0);
      checkOutput("rst_err", err, 0);
      rst_n = 1'b1;
      applyStimulus(8'h00, 1'b1, 6);

      // Bounce never reaches DEBOUNCE_CYCLES of stable low
      applyStimulus(8'h55, 1'b0, 2);
      applyStimulus(8'h55, 1'b1, 1);
      applyStimulus(8'h55, 1'b0, 2);
      applyStimulus(8'h55, 1'b1, 10);
      checkOutput("bounce_valids", valid_count, 0);
      checkOutput("bounce_code", code, 0);
      checkOutput("bounce_cnt", capture_cnt, 0);

      // Clean press with latency measurement
      applyStimulus(8'h09, 1'b1, 4);
      exp_q.push_back('{code: 8'h09, cnt: 4'd1});
      v0 = valid_count;
      first_edge = -1;
      key_raw_n = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (code_valid && first_edge < 0) first_edge = i;
      end
      checkOutput("press_latency", first_edge, 8);
      checkOutput("press_pulses", valid_count - v0, 1);
      checkOutput("press_code", code, 8'h09);
      checkOutput("press_loaded", code_loaded, 1);
      checkOutput("press_cnt", capture_cnt, 1);
      applyStimulus(8'h09, 1'b1, 12);

      // Long hold yields a single capture; release bounces, then re-press
      exp_q.push_back('{code: 8'h3C, cnt: 4'd2});
      v0 = valid_count;
      applyStimulus(8'h3C, 1'b1, 4);
      applyStimulus(8'h3C, 1'b0, 100);
      checkOutput("hold_pulses", valid_count - v0, 1);
      checkOutput("hold_code", code, 8'h3C);
      applyStimulus(8'h3C, 1'b1, 2);
      applyStimulus(8'h3C, 1'b0, 1);
      applyStimulus(8'hA5, 1'b1, 10);
      exp_q.push_back('{code: 8'hA5, cnt: 4'd3});
      applyStimulus(8'hA5, 1'b0, 12);
      checkOutput("repress_code", code, 8'hA5);
      checkOutput("repress_cnt", capture_cnt, 3);
      applyStimulus(8'hA5, 1'b1, 12);

      // Reset lands mid-debounce, asynchronously; key stays held afterwards
      applyStimulus(8'hA5, 1'b0, 5);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_code", code, 0);
      checkOutput("async_rst_valid", code_valid, 0);
      checkOutput("async_rst_loaded", code_loaded, 0);
      checkOutput("async_rst_cnt", capture_cnt, 0);
      checkOutput("async_rst_err", err, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v0 = valid_count;
      applyStimulus(8'hA5, 1'b0, 30);
      checkOutput("held_after_rst_pulses", valid_count - v0, 0);
      checkOutput("held_after_rst_loaded", code_loaded, 0);
      checkOutput("held_after_rst_cnt", capture_cnt, 0);
      applyStimulus(8'hA5, 1'b1, 12);
      pressRelease(8'hA5, 4'd1);
      checkOutput("after_rst_code", code, 8'hA5);

      // Fifteen more presses bring the count to sixteen, wrapping to zero
      for (int i = 2; i <= 16; i++) pressRelease(8'(i * 3), 4'(i));
      checkOutput("wrap_cnt", capture_cnt, 0);
      checkOutput("wrap_loaded", code_loaded, 1);
      checkOutput("wrap_code", code, 8'h30);

      // Switch bit 3 moves while the key is being debounced
      applyStimulus(8'h10, 1'b1, 4);
      e0 = err_count;
      v0 = valid_count;
`ifndef CODE_CAPTURE_STABLE_EN
      exp_q.push_back('{code: 8'h18, cnt: 4'd1});
`endif
      applyStimulus(8'h10, 1'b0, 3);
      applyStimulus(8'h18, 1'b0, 9);
      applyStimulus(8'h18, 1'b1, 12);
`ifdef CODE_CAPTURE_STABLE_EN
      checkOutput("unstable_err_pulses", err_count - e0, 1);
      checkOutput("unstable_valids", valid_count - v0, 0);
      checkOutput("unstable_code", code, 8'h30);
      checkOutput("unstable_cnt", capture_cnt, 0);
`else
      checkOutput("unstable_err_pulses", err_count - e0, 0);
      checkOutput("unstable_valids", valid_count - v0, 1);
      checkOutput("unstable_code", code, 8'h18);
      checkOutput("unstable_cnt", capture_cnt, 1);
      checkOutput("err_never", err_count, 0);
`endif

      checkOutput("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
